// File: rtl/hdp_spi_master.sv
// HDP serial-bus master: shifts one 16-bit register-access frame (rw, addr, data) MSB first
// on SEN/SCK/SDAT and captures the read byte from SOUT through a start/busy/done handshake.
module hdp_spi_master #(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned GAP_CYCLES = 4
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic       i_rw,
   input  logic [6:0] i_addr,
   input  logic [7:0] i_wdata,
   output logic       o_busy,
   output logic       o_done,
   output logic [7:0] o_rdata,
   input  logic       i_sout,
   output logic       o_sen,
   output logic       o_sck,
   output logic       o_sdat
);

   localparam int unsigned MaxCnt = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
   localparam int unsigned CntW   = $clog2(MaxCnt + 1);
   localparam logic [CntW-1:0] DivLast = CntW'(CLK_DIV - 1);
   localparam logic [CntW-1:0] GapLast = CntW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StShift, StHold, StGap} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            phase_q, phase_d;
   logic [3:0]      bit_q, bit_d;
   logic [15:0]     frame_q, frame_d;
   logic [7:0]      rx_q, rx_d;
   logic [7:0]      rdata_q, rdata_d;
   logic            done_q, done_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      bit_d   = bit_q;
      frame_d = frame_q;
      rx_d    = rx_q;
      rdata_d = rdata_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (i_start) begin
               frame_d = {i_rw, i_addr, (i_rw ? 8'h00 : i_wdata)};
               cnt_d   = '0;
               phase_d = 1'b0;
               bit_d   = 4'd15;
               state_d = StShift;
            end
         end
         StShift: begin
            if (cnt_q == DivLast) begin
               cnt_d = '0;
               if (!phase_q) begin
                  phase_d = 1'b1;
                  // This edge raises SCK; the data phase (bits 7..0) samples SOUT here.
                  if (!bit_q[3]) begin
                     rx_d = {rx_q[6:0], i_sout};
                  end
               end else begin
                  phase_d = 1'b0;
                  if (bit_q == 4'd0) begin
                     state_d = StHold;
                  end else begin
                     bit_d = bit_q - 4'd1;
                  end
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StHold: begin
            if (cnt_q == DivLast) begin
               cnt_d   = '0;
               state_d = StGap;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StGap: begin
            if (cnt_q == GapLast) begin
               cnt_d   = '0;
               state_d = StIdle;
               done_d  = 1'b1;
               if (frame_q[15]) begin
                  rdata_d = rx_q;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         phase_q <= 1'b0;
         bit_q   <= 4'd0;
         frame_q <= 16'h0000;
         rx_q    <= 8'h00;
         rdata_q <= 8'h00;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         frame_q <= frame_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      o_sen   = !((state_q == StShift) || (state_q == StHold));
      o_sck   = (state_q == StShift) && phase_q;
      // HOLD keeps bit_q at 0, so SDAT keeps presenting bit 0 there.
      o_sdat  = ((state_q == StShift) || (state_q == StHold)) ? frame_q[bit_q] : 1'b0;
      o_busy  = (state_q != StIdle);
      o_done  = done_q;
      o_rdata = rdata_q;
   end

endmodule

// File: tb/tb_hdp_spi_master.sv
// Directed bench for hdp_spi_master: default-timing instance plus a CLK_DIV=1/GAP_CYCLES=1
// instance, with a simple panel model driving SOUT on SCK falling edges.
module tb_hdp_spi_master;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       sel = 1'b0;
   logic       rw = 1'b0;
   logic [6:0] addr = 7'h00;
   logic [7:0] wdata = 8'h00;
   logic       sout = 1'b0;

   logic       start0, start1;
   logic       busy0, done0, sen0, sck0, sdat0;
   logic       busy1, done1, sen1, sck1, sdat1;
   logic [7:0] rdata0, rdata1;
   logic       obusy, odone, osen, osck, osdat;
   logic [7:0] ordata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign start0 = start & ~sel;
   assign start1 = start & sel;
   assign obusy  = sel ? busy1 : busy0;
   assign odone  = sel ? done1 : done0;
   assign osen   = sel ? sen1 : sen0;
   assign osck   = sel ? sck1 : sck0;
   assign osdat  = sel ? sdat1 : sdat0;
   assign ordata = sel ? rdata1 : rdata0;

   hdp_spi_master #(.CLK_DIV(4), .GAP_CYCLES(4)) u_dut0 (
      .i_clock(clk), .i_reset(rst), .i_start(start0), .i_rw(rw), .i_addr(addr),
      .i_wdata(wdata), .o_busy(busy0), .o_done(done0), .o_rdata(rdata0), .i_sout(sout),
      .o_sen(sen0), .o_sck(sck0), .o_sdat(sdat0)
   );

   hdp_spi_master #(.CLK_DIV(1), .GAP_CYCLES(1)) u_dut1 (
      .i_clock(clk), .i_reset(rst), .i_start(start1), .i_rw(rw), .i_addr(addr),
      .i_wdata(wdata), .o_busy(busy1), .o_done(done1), .o_rdata(rdata1), .i_sout(sout),
      .o_sen(sen1), .o_sck(sck1), .o_sdat(sdat1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one frame and collects pin statistics; cycle numbers are relative to acceptance.
   task automatic run_frame(input logic do_start, input logic f_rw, input logic [6:0] f_addr,
                            input logic [7:0] f_wdata, input logic [7:0] panel,
                            input int inj_cyc, input logic chain, input int max_cyc,
                            output logic [15:0] bits, output int rises, output int toggles,
                            output int sen_first, output int sen_last, output int sen_falls,
                            output int done_cyc, output int done_cnt,
                            output logic [7:0] rd_at_done, output int busy_bad);
      logic prev_sck = 1'b0;
      logic prev_sen = 1'b1;
      bits = 16'h0000; rises = 0; toggles = 0; sen_first = -1; sen_last = -1;
      sen_falls = 0; done_cyc = -1; done_cnt = 0; rd_at_done = 8'hxx; busy_bad = 0;
      if (do_start) begin
         rw = f_rw; addr = f_addr; wdata = f_wdata; start = 1'b1;
         step();
         start = 1'b0;
      end else begin
         sen_falls = 1;
      end
      for (int c = 1; c <= max_cyc; c++) begin
         if (c == inj_cyc) begin
            start = 1'b1; addr = 7'h33;
         end
         if (osck !== prev_sck) toggles++;
         if (osck === 1'b1 && prev_sck === 1'b0) begin
            bits = {bits[14:0], osdat};
            rises++;
         end
         if (prev_sck === 1'b1 && osck === 1'b0 && rises >= 8 && rises < 16)
            sout = panel[15-rises];
         if (osen === 1'b0) begin
            if (sen_first < 0) sen_first = c;
            sen_last = c;
            if (prev_sen === 1'b1) sen_falls++;
         end
         if (odone === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc = c;
               rd_at_done = ordata;
            end
            if (obusy !== 1'b0) busy_bad++;
         end else if (done_cyc < 0 && obusy !== 1'b1) begin
            busy_bad++;
         end
         prev_sck = osck;
         prev_sen = osen;
         if (odone === 1'b1 && chain) begin
            start = 1'b1;
            step();
            start = 1'b0;
            return;
         end
         step();
         start = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #0;
         checks++;
         if ({osen, osck, osdat, obusy, odone, ordata} !== {5'b10000, 8'h00}) begin
            errors++;
            $display("FAIL reset_state dut%0d: got sen/sck/sdat/busy/done/rdata=%b%b%b%b%b/%h, want 10000/00",
                     s, osen, osck, osdat, obusy, odone, ordata);
         end
      end
      sel = 1'b0;
      rst = 1'b0;
      step();
   endtask

   task automatic test_write(input logic [6:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
      logic [15:0] bits; logic [7:0] rd;
      int rises, tog, sf, sl, sfall, dc, dn, bb;
      run_frame(1'b1, 1'b0, a, d, 8'h00, -1, 1'b0, 150, bits, rises, tog, sf, sl, sfall,
                dc, dn, rd, bb);
      checks++;
      if (bits !== {1'b0, a, d}) begin
         errors++; $display("FAIL write_bits: got %h, want %h", bits, {1'b0, a, d});
      end
      checks++;
      if (sf != 1 || sl != 132 || sfall != 1) begin
         errors++; $display("FAIL write_sen: got first=%0d last=%0d falls=%0d, want 1 132 1", sf, sl, sfall);
      end
      checks++;
      if (rises != 16 || tog != 32) begin
         errors++; $display("FAIL write_sck: got rises=%0d toggles=%0d, want 16 32", rises, tog);
      end
      checks++;
      if (dc != 137 || dn != 1) begin
         errors++; $display("FAIL write_done: got cycle=%0d count=%0d, want 137 1", dc, dn);
      end
      checks++;
      if (bb != 0 || ordata !== exp_rd) begin
         errors++; $display("FAIL write_busy_rdata: got busy_bad=%0d rdata=%h, want 0 %h", bb, ordata, exp_rd);
      end
   endtask

   task automatic test_read();
      logic [15:0] bits; logic [7:0] rd;
      int rises, tog, sf, sl, sfall, dc, dn, bb;
      run_frame(1'b1, 1'b1, 7'h7f, 8'h5a, 8'ha5, -1, 1'b0, 150, bits, rises, tog, sf, sl, sfall,
                dc, dn, rd, bb);
      checks++;
      if (bits !== 16'hff00) begin
         errors++; $display("FAIL read_bits: got %h, want ff00", bits);
      end
      checks++;
      if (dc != 137 || rd !== 8'ha5) begin
         errors++; $display("FAIL read_done_rdata: got cycle=%0d rdata=%h, want 137 a5", dc, rd);
      end
      checks++;
      if (ordata !== 8'ha5 || bb != 0) begin
         errors++; $display("FAIL read_rdata_hold: got rdata=%h busy_bad=%0d, want a5 0", ordata, bb);
      end
   endtask

   task automatic test_busy_reject();
      logic [15:0] bits; logic [7:0] rd;
      int rises, tog, sf, sl, sfall, dc, dn, bb;
      run_frame(1'b1, 1'b0, 7'h21, 8'h9c, 8'h00, 50, 1'b0, 300, bits, rises, tog, sf, sl, sfall,
                dc, dn, rd, bb);
      checks++;
      if (bits !== 16'h219c || rises != 16) begin
         errors++; $display("FAIL busy_reject_bits: got %h rises=%0d, want 219c 16", bits, rises);
      end
      checks++;
      if (sfall != 1 || dn != 1 || dc != 137) begin
         errors++; $display("FAIL busy_reject_frames: got sen_falls=%0d done=%0d at %0d, want 1 1 137",
                            sfall, dn, dc);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] bits; logic [7:0] rd;
      int rises, tog, sf, sl, sfall, dc, dn, bb;
      int sl1, dc1;
      run_frame(1'b1, 1'b0, 7'h0a, 8'h3c, 8'h00, -1, 1'b1, 150, bits, rises, tog, sf, sl, sfall,
                dc, dn, rd, bb);
      sl1 = sl; dc1 = dc;
      run_frame(1'b0, 1'b0, 7'h0a, 8'h3c, 8'h00, -1, 1'b0, 150, bits, rises, tog, sf, sl, sfall,
                dc, dn, rd, bb);
      checks++;
      if (sf != 1 || (dc1 - sl1) + (sf - 1) != 5) begin
         errors++; $display("FAIL b2b_gap: got sen_first=%0d gap=%0d, want 1 5", sf, (dc1 - sl1) + (sf - 1));
      end
      checks++;
      if (bits !== 16'h0a3c || dc != 137) begin
         errors++; $display("FAIL b2b_second: got %h done=%0d, want 0a3c 137", bits, dc);
      end
   endtask

   task automatic test_reset_mid_frame();
      int dn = 0;
      rw = 1'b0; addr = 7'h11; wdata = 8'h22; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c < 40; c++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({osen, osck, obusy, odone, ordata} !== {4'b1000, 8'h00}) begin
         errors++;
         $display("FAIL reset_mid_frame: got sen/sck/busy/done/rdata=%b%b%b%b/%h, want 1000/00",
                  osen, osck, obusy, odone, ordata);
      end
      for (int c = 0; c < 150; c++) begin
         if (odone !== 1'b0 || osen !== 1'b1) dn++;
         step();
      end
      checks++;
      if (dn != 0) begin
         errors++; $display("FAIL reset_no_done: got %0d bad cycles, want 0", dn);
      end
      test_write(7'h44, 8'h81, 8'h00);
   endtask

   task automatic test_fast();
      logic [15:0] bits; logic [7:0] rd;
      int rises, tog, sf, sl, sfall, dc, dn, bb;
      sel = 1'b1;
      #0;
      run_frame(1'b1, 1'b1, 7'h7f, 8'h00, 8'h3c, -1, 1'b0, 60, bits, rises, tog, sf, sl, sfall,
                dc, dn, rd, bb);
      checks++;
      if (bits !== 16'hff00 || rises != 16 || tog != 32) begin
         errors++; $display("FAIL fast_sck: got %h rises=%0d toggles=%0d, want ff00 16 32", bits, rises, tog);
      end
      checks++;
      if (sf != 1 || sl != 33 || dc != 35 || dn != 1) begin
         errors++; $display("FAIL fast_timing: got sen %0d..%0d done=%0d x%0d, want 1..33 35 x1",
                            sf, sl, dc, dn);
      end
      checks++;
      if (rd !== 8'h3c) begin
         errors++; $display("FAIL fast_rdata: got %h, want 3c", rd);
      end
      sel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write(7'h05, 8'h12, 8'h00);
      test_read();
      test_write(7'h06, 8'h77, 8'ha5);
      test_busy_reject();
      test_back_to_back();
      test_reset_mid_frame();
      test_fast();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
